// File: rtl/alarm_timekeeper.sv
// alarm_timekeeper: 24-hour timekeeper with N alarm channels, snooze and ringing auto-stop.
// Revision 1.0
`default_nettype none

module alarm_timekeeper #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int N_ALARM      = 2,
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_SEC     = 60,
  parameter int MAX_SNOOZE   = 3,
  parameter int ALARM_RST_HR = 7,
  localparam int SEL_W       = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [1:0]         mode,
  input  logic               inc_min,
  input  logic               inc_hr,
  input  logic [SEL_W-1:0]   alarm_sel,
  input  logic [N_ALARM-1:0] alarm_en,
  input  logic               snooze,
  input  logic               stop,
  output logic [4:0]         hours,
  output logic [5:0]         minutes,
  output logic [5:0]         seconds,
  output logic               sec_pulse,
  output logic [4:0]         alarm_hr,
  output logic [5:0]         alarm_mn,
  output logic               play,
  output logic [SEL_W-1:0]   ring_ch,
  output logic [3:0]         snooze_left
);

  localparam int PRE_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int CD_MAX = SNOOZE_MIN * 60;
  localparam int CD_W   = $clog2(CD_MAX + 1);
  localparam int RT_W   = $clog2(RING_SEC + 1);

  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(CLK_HZ - 1);
  localparam logic [CD_W-1:0]  CD_LOAD     = CD_W'(CD_MAX);
  localparam logic [RT_W-1:0]  RT_LAST     = RT_W'(RING_SEC);
  localparam logic [3:0]       SNZ_INIT    = 4'(MAX_SNOOZE);
  localparam logic [4:0]       ALM_HR_INIT = 5'(ALARM_RST_HR);
  localparam logic [1:0]       MODE_SET_TIME  = 2'd1;
  localparam logic [1:0]       MODE_SET_ALARM = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } state_t;

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic             is_run;

  assign tick   = (pre_cnt == PRE_LAST);
  assign is_run = (mode != MODE_SET_TIME) && (mode != MODE_SET_ALARM);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pre_cnt   <= '0;
      sec_pulse <= 1'b0;
    end else begin
      pre_cnt   <= tick ? '0 : pre_cnt + PRE_W'(1);
      sec_pulse <= tick;
    end
  end

  logic [4:0] hr_inc;
  logic [5:0] mn_inc, sc_inc;
  logic [4:0] run_h;
  logic [5:0] run_m, run_s;

  assign sc_inc = (seconds == 6'd59) ? 6'd0 : seconds + 6'd1;
  assign mn_inc = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
  assign hr_inc = (hours == 5'd23) ? 5'd0 : hours + 5'd1;

  // Time after one second tick, also the value the alarm match looks at.
  always_comb begin
    run_h = hours;
    run_m = minutes;
    run_s = sc_inc;
    if (seconds == 6'd59) begin
      run_m = mn_inc;
      if (minutes == 6'd59) run_h = hr_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hours   <= '0;
      minutes <= '0;
      seconds <= '0;
    end else if (mode == MODE_SET_TIME) begin
      if (inc_min) begin
        minutes <= mn_inc;
        seconds <= '0;
      end
      if (inc_hr) hours <= hr_inc;
    end else if (tick) begin
      hours   <= run_h;
      minutes <= run_m;
      seconds <= run_s;
    end
  end

  logic [4:0] alm_hr [N_ALARM];
  logic [5:0] alm_mn [N_ALARM];

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_ALARM; i++) begin
      if (!reset_n) begin
        alm_hr[i] <= ALM_HR_INIT;
        alm_mn[i] <= '0;
      end else if ((mode == MODE_SET_ALARM) && (alarm_sel == SEL_W'(i))) begin
        if (inc_min) alm_mn[i] <= (alm_mn[i] == 6'd59) ? 6'd0 : alm_mn[i] + 6'd1;
        if (inc_hr)  alm_hr[i] <= (alm_hr[i] == 5'd23) ? 5'd0 : alm_hr[i] + 5'd1;
      end
    end
  end

  logic             match_any;
  logic             match;
  logic [SEL_W-1:0] match_ch;
  logic             ring_en;

  always_comb begin
    alarm_hr  = '0;
    alarm_mn  = '0;
    match_any = 1'b0;
    match_ch  = '0;
    ring_en   = 1'b0;
    // Scanning downward leaves the lowest matching channel as the winner.
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (alarm_sel == SEL_W'(i)) begin
        alarm_hr = alm_hr[i];
        alarm_mn = alm_mn[i];
      end
      if (ring_ch == SEL_W'(i)) ring_en = alarm_en[i];
      if (alarm_en[i] && (alm_hr[i] == run_h) && (alm_mn[i] == run_m)) begin
        match_any = 1'b1;
        match_ch  = SEL_W'(i);
      end
    end
  end

  assign match = match_any && tick && is_run && (run_s == 6'd0);

  state_t           state, state_d;
  logic [RT_W-1:0]  ring_tmr, ring_tmr_d, ring_tmr_inc;
  logic [CD_W-1:0]  cd, cd_d;
  logic [SEL_W-1:0] ring_ch_d;
  logic [3:0]       snooze_left_d;

  assign ring_tmr_inc = ring_tmr + RT_W'(1);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      ring_tmr    <= '0;
      cd          <= '0;
      ring_ch     <= '0;
      snooze_left <= SNZ_INIT;
      play        <= 1'b0;
    end else begin
      state       <= state_d;
      ring_tmr    <= ring_tmr_d;
      cd          <= cd_d;
      ring_ch     <= ring_ch_d;
      snooze_left <= snooze_left_d;
      play        <= (state == ST_RINGING);
    end
  end

  always_comb begin
    state_d       = state;
    ring_tmr_d    = ring_tmr;
    cd_d          = cd;
    ring_ch_d     = ring_ch;
    snooze_left_d = snooze_left;
    if ((state != ST_IDLE) && !is_run) begin
      state_d = ST_IDLE;
    end else if (match) begin
      state_d       = ST_RINGING;
      ring_ch_d     = match_ch;
      snooze_left_d = SNZ_INIT;
      ring_tmr_d    = '0;
    end else if ((state != ST_IDLE) && !ring_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_RINGING: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (snooze) begin
            if (snooze_left != 4'd0) begin
              state_d       = ST_SNOOZED;
              snooze_left_d = snooze_left - 4'd1;
              cd_d          = CD_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (tick) begin
            ring_tmr_d = ring_tmr_inc;
            if (ring_tmr_inc == RT_LAST) state_d = ST_IDLE;
          end
        end
        ST_SNOOZED: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (tick) begin
            cd_d = cd - CD_W'(1);
            if (cd == CD_W'(1)) begin
              state_d    = ST_RINGING;
              ring_tmr_d = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alarm_timekeeper.sv
// tb_alarm_timekeeper: randomized and scenario bench for alarm_timekeeper against a seconds-of-day model.
// Revision 1.0
`default_nettype none

module tb_alarm_timekeeper;

  localparam int HZ = 4, NA = 2, SNM = 1, RS = 3, MS = 3, ARH = 7;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       inc_min = 1'b0, inc_hr = 1'b0;
  logic [0:0] alarm_sel = 1'b0;
  logic [1:0] alarm_en = 2'b00;
  logic       snooze = 1'b0, stop = 1'b0;
  logic [4:0] hours, alarm_hr;
  logic [5:0] minutes, seconds, alarm_mn;
  logic       sec_pulse, play;
  logic [0:0] ring_ch;
  logic [3:0] snooze_left;

  int n_checks = 0;
  int n_pass = 0;

  alarm_timekeeper #(
    .CLK_HZ(HZ), .N_ALARM(NA), .SNOOZE_MIN(SNM), .RING_SEC(RS),
    .MAX_SNOOZE(MS), .ALARM_RST_HR(ARH)
  ) dut (
    .clock(clock), .reset_n(reset_n), .mode(mode), .inc_min(inc_min), .inc_hr(inc_hr),
    .alarm_sel(alarm_sel), .alarm_en(alarm_en), .snooze(snooze), .stop(stop),
    .hours(hours), .minutes(minutes), .seconds(seconds), .sec_pulse(sec_pulse),
    .alarm_hr(alarm_hr), .alarm_mn(alarm_mn), .play(play), .ring_ch(ring_ch),
    .snooze_left(snooze_left)
  );

  always #5 clock = ~clock;

  // Reference state: time as seconds of day, alarms as minute of day, state 0/1/2 = idle/ringing/snoozed.
  int m_pre = 0, m_tod = 0, m_st = 0, m_timer = 0, m_cd = 0, m_ch = 0, m_left = MS;
  int m_al[NA] = '{ARH * 60, ARH * 60};
  bit m_play = 1'b0, m_sp = 1'b0;

  logic [34:0] dut_vec;
  assign dut_vec = {hours, minutes, seconds, sec_pulse, play, ring_ch, snooze_left, alarm_hr, alarm_mn};

  localparam logic [34:0] RESET_VEC = {5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 4'd3, 5'd7, 6'd0};

  function automatic logic [34:0] exp_vec();
    int sel = int'(alarm_sel);
    return {5'(m_tod / 3600), 6'((m_tod / 60) % 60), 6'(m_tod % 60), m_sp, m_play,
            1'(m_ch), 4'(m_left), 5'(m_al[sel] / 60), 6'(m_al[sel] % 60)};
  endfunction

  function automatic void model_edge();
    bit tick, run, match;
    int nt, h, mi, s, mch, sel;
    if (!reset_n) begin
      m_pre = 0; m_tod = 0; m_st = 0; m_timer = 0; m_cd = 0; m_ch = 0; m_left = MS;
      m_play = 1'b0; m_sp = 1'b0;
      for (int i = 0; i < NA; i++) m_al[i] = ARH * 60;
      return;
    end
    tick   = (m_pre == HZ - 1);
    run    = (mode == 2'd0) || (mode == 2'd3);
    m_play = (m_st == 1);
    m_sp   = tick;
    m_pre  = tick ? 0 : m_pre + 1;
    nt = m_tod;
    if (mode == 2'd1) begin
      h = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
      if (inc_min) begin mi = (mi + 1) % 60; s = 0; end
      if (inc_hr) h = (h + 1) % 24;
      nt = h * 3600 + mi * 60 + s;
    end else if (tick) begin
      nt = (m_tod + 1) % 86400;
    end
    match = 1'b0; mch = 0;
    if (run && tick && (nt % 60 == 0))
      for (int i = NA - 1; i >= 0; i--)
        if (alarm_en[i] && m_al[i] == nt / 60) begin match = 1'b1; mch = i; end
    sel = int'(alarm_sel);
    if (mode == 2'd2 && sel < NA) begin
      h = m_al[sel] / 60; mi = m_al[sel] % 60;
      if (inc_min) mi = (mi + 1) % 60;
      if (inc_hr) h = (h + 1) % 24;
      m_al[sel] = h * 60 + mi;
    end
    m_tod = nt;
    if (m_st != 0 && !run) m_st = 0;
    else if (match) begin m_st = 1; m_ch = mch; m_left = MS; m_timer = 0; end
    else if (m_st != 0 && !alarm_en[m_ch]) m_st = 0;
    else if (m_st == 1) begin
      if (stop) m_st = 0;
      else if (snooze) begin
        if (m_left > 0) begin m_st = 2; m_left--; m_cd = SNM * 60; end
        else m_st = 0;
      end else if (tick) begin
        m_timer++;
        if (m_timer == RS) m_st = 0;
      end
    end else if (m_st == 2) begin
      if (stop) m_st = 0;
      else if (tick) begin
        m_cd--;
        if (m_cd == 0) begin m_st = 1; m_timer = 0; end
      end
    end
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic press(input logic m, input logic h);
    inc_min = m; inc_hr = h;
    step();
    inc_min = 1'b0; inc_hr = 1'b0;
    step();
  endtask

  task automatic run_cycles(input int n, output int pulses, output int plays, output int mism);
    pulses = 0; plays = 0; mism = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (sec_pulse === 1'b1) pulses++;
      if (play === 1'b1) plays++;
      if (dut_vec !== exp_vec()) mism++;
    end
  endtask

  task automatic wait_play(input logic target, input int limit, output int pulses, output int mism,
                           output bit ok);
    int n = 0;
    pulses = 0; mism = 0;
    step(); n++;
    if (sec_pulse === 1'b1) pulses++;
    if (dut_vec !== exp_vec()) mism++;
    while (play !== target && n < limit) begin
      step(); n++;
      if (sec_pulse === 1'b1) pulses++;
      if (dut_vec !== exp_vec()) mism++;
    end
    ok = (play === target);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; mode = 2'd0; alarm_en = 2'b00; alarm_sel = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step(); step();
    n_checks++;
    if (dut_vec !== RESET_VEC) $display("FAIL reset_state: got %h expected %h", dut_vec, RESET_VEC);
    else n_pass++;
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL reset_model: got %h expected %h", dut_vec, exp_vec());
    else n_pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_tick();
    int pulses, plays, mism;
    run_cycles(240, pulses, plays, mism);
    n_checks++;
    if (pulses != 60) $display("FAIL tick_pulses: got %0d expected 60", pulses); else n_pass++;
    n_checks++;
    if ({hours, minutes, seconds} !== {5'd0, 6'd1, 6'd0})
      $display("FAIL tick_time: got %0d:%0d:%0d expected 0:1:0", hours, minutes, seconds);
    else n_pass++;
    n_checks++;
    if (mism != 0) $display("FAIL tick_model: got %0d mismatching cycles expected 0", mism); else n_pass++;
  endtask

  task automatic test_wrap();
    int n, mism;
    do_reset();
    mode = 2'd1;
    for (int i = 0; i < 23; i++) press(1'b0, 1'b1);
    for (int i = 0; i < 59; i++) press(1'b1, 1'b0);
    n_checks++;
    if ({hours, minutes, seconds} !== {5'd23, 6'd59, 6'd0})
      $display("FAIL wrap_preset: got %0d:%0d:%0d expected 23:59:0", hours, minutes, seconds);
    else n_pass++;
    mode = 2'd0;
    n = 0; mism = 0;
    while (m_tod != 86398 && n < 400) begin
      step(); n++;
      if (dut_vec !== exp_vec()) mism++;
    end
    n_checks++;
    if (m_tod != 86398 || {hours, minutes, seconds} !== {5'd23, 6'd59, 6'd58})
      $display("FAIL wrap_reach: got %0d:%0d:%0d expected 23:59:58", hours, minutes, seconds);
    else n_pass++;
    n = 0;
    while (m_tod != 0 && n < 20) begin
      step(); n++;
      if (dut_vec !== exp_vec()) mism++;
    end
    n_checks++;
    if ({hours, minutes, seconds} !== 17'd0)
      $display("FAIL wrap_midnight: got %0d:%0d:%0d expected 0:0:0", hours, minutes, seconds);
    else n_pass++;
    n_checks++;
    if (mism != 0) $display("FAIL wrap_model: got %0d mismatching cycles expected 0", mism); else n_pass++;
  endtask

  task automatic test_alarm();
    int pulses, mism;
    bit ok;
    do_reset();
    mode = 2'd2; alarm_sel = 1'b0;
    for (int i = 0; i < 17; i++) press(1'b0, 1'b1);
    press(1'b1, 1'b0); press(1'b1, 1'b0);
    n_checks++;
    if ({alarm_hr, alarm_mn} !== {5'd0, 6'd2})
      $display("FAIL alarm_set: got %0d:%0d expected 0:2", alarm_hr, alarm_mn);
    else n_pass++;
    mode = 2'd1;
    press(1'b1, 1'b0);
    alarm_en = 2'b01; mode = 2'd0;
    wait_play(1'b1, 300, pulses, mism, ok);
    n_checks++;
    if (!ok || {hours, minutes, seconds, ring_ch, snooze_left} !== {5'd0, 6'd2, 6'd0, 1'b0, 4'd3})
      $display("FAIL alarm_ring: got play=%0b %0d:%0d:%0d ch=%0d left=%0d expected play=1 0:2:0 ch=0 left=3",
               play, hours, minutes, seconds, ring_ch, snooze_left);
    else n_pass++;
    n_checks++;
    if (mism != 0) $display("FAIL alarm_model: got %0d mismatching cycles expected 0", mism); else n_pass++;
    wait_play(1'b0, 40, pulses, mism, ok);
    n_checks++;
    if (!ok || pulses != RS)
      $display("FAIL alarm_autostop: got play=%0b after %0d ticks expected play=0 after %0d", play, pulses, RS);
    else n_pass++;
  endtask

  task automatic test_snooze();
    int pulses, plays, mism;
    bit ok;
    mode = 2'd2; alarm_sel = 1'b0;
    press(1'b1, 1'b0);
    mode = 2'd0;
    wait_play(1'b1, 400, pulses, mism, ok);
    n_checks++;
    if (!ok || mism != 0) $display("FAIL snooze_first_ring: got play=%0b mism=%0d expected play=1 mism=0", play, mism);
    else n_pass++;
    for (int k = 0; k < MS; k++) begin
      snooze = 1'b1; step(); snooze = 1'b0;
      wait_play(1'b1, 300, pulses, mism, ok);
      n_checks++;
      if (!ok || pulses != SNM * 60 || snooze_left !== 4'(MS - 1 - k) || mism != 0)
        $display("FAIL snooze_cycle%0d: got play=%0b ticks=%0d left=%0d mism=%0d expected play=1 ticks=%0d left=%0d mism=0",
                 k, play, pulses, snooze_left, mism, SNM * 60, MS - 1 - k);
      else n_pass++;
    end
    snooze = 1'b1; step(); snooze = 1'b0;
    run_cycles(100, pulses, plays, mism);
    n_checks++;
    if (plays != 0 || snooze_left !== 4'd0 || mism != 0)
      $display("FAIL snooze_exhausted: got plays=%0d left=%0d mism=%0d expected plays=0 left=0 mism=0",
               plays, snooze_left, mism);
    else n_pass++;
  endtask

  task automatic test_priority();
    int pulses, plays, mism;
    bit ok;
    do_reset();
    mode = 2'd2;
    for (int s = 0; s < NA; s++) begin
      alarm_sel = 1'(s);
      for (int i = 0; i < 17; i++) press(1'b0, 1'b1);
      press(1'b1, 1'b0);
    end
    n_checks++;
    if ({alarm_hr, alarm_mn} !== {5'd0, 6'd1})
      $display("FAIL prio_alarm1: got %0d:%0d expected 0:1", alarm_hr, alarm_mn);
    else n_pass++;
    alarm_en = 2'b11; mode = 2'd0;
    wait_play(1'b1, 300, pulses, mism, ok);
    n_checks++;
    if (!ok || ring_ch !== 1'b0 || mism != 0)
      $display("FAIL prio_lowest: got play=%0b ch=%0d mism=%0d expected play=1 ch=0 mism=0", play, ring_ch, mism);
    else n_pass++;
    stop = 1'b1; snooze = 1'b1; step(); stop = 1'b0; snooze = 1'b0;
    run_cycles(20, pulses, plays, mism);
    n_checks++;
    if (play !== 1'b0 || plays > 1 || snooze_left !== 4'd3 || mism != 0)
      $display("FAIL prio_stop_wins: got play=%0b plays=%0d left=%0d mism=%0d expected play=0 left=3 mism=0",
               play, plays, snooze_left, mism);
    else n_pass++;
  endtask

  task automatic test_mode_exit();
    int pulses, mism;
    bit ok;
    mode = 2'd2; alarm_sel = 1'b1;
    press(1'b1, 1'b0);
    alarm_en = 2'b10; mode = 2'd0;
    wait_play(1'b1, 300, pulses, mism, ok);
    n_checks++;
    if (!ok || ring_ch !== 1'b1 || mism != 0)
      $display("FAIL mode_ring: got play=%0b ch=%0d mism=%0d expected play=1 ch=1 mism=0", play, ring_ch, mism);
    else n_pass++;
    mode = 2'd1;
    step(); step();
    n_checks++;
    if (play !== 1'b0 || dut_vec !== exp_vec())
      $display("FAIL mode_exit: got play=%0b vec=%h expected play=0 vec=%h", play, dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_reset_mid_snooze();
    int pulses, plays, mism;
    bit ok;
    mode = 2'd2; alarm_sel = 1'b1;
    press(1'b1, 1'b0);
    mode = 2'd0;
    wait_play(1'b1, 300, pulses, mism, ok);
    snooze = 1'b1; step(); snooze = 1'b0;
    run_cycles(3, pulses, plays, mism);
    n_checks++;
    if (!ok || play !== 1'b0 || snooze_left !== 4'd2 || mism != 0)
      $display("FAIL midsnooze_setup: got play=%0b left=%0d mism=%0d expected play=0 left=2 mism=0",
               play, snooze_left, mism);
    else n_pass++;
    reset_n = 1'b0;
    step();
    n_checks++;
    if (dut_vec !== RESET_VEC) $display("FAIL midsnooze_reset: got %h expected %h", dut_vec, RESET_VEC);
    else n_pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    int mism = 0, rings = 0;
    do_reset();
    mode = 2'd2;
    alarm_sel = 1'b0;
    for (int i = 0; i < 17; i++) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    alarm_sel = 1'b1;
    for (int i = 0; i < 17; i++) press(1'b0, 1'b1);
    press(1'b1, 1'b0); press(1'b1, 1'b0);
    alarm_en = 2'b11; mode = 2'd0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) < 2) begin
        case ($urandom_range(0, 5))
          0: mode = 2'd1;
          1: mode = 2'd2;
          2: mode = 2'd3;
          default: mode = 2'd0;
        endcase
      end
      inc_min   = ($urandom_range(0, 99) < 4);
      inc_hr    = ($urandom_range(0, 99) < 2);
      snooze    = ($urandom_range(0, 99) < 3);
      stop      = ($urandom_range(0, 99) < 2);
      alarm_sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) alarm_en = 2'($urandom_range(0, 3));
      step();
      if (play === 1'b1) rings++;
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        mism++;
        $display("FAIL random_cycle%0d: got %h expected %h", c, dut_vec, exp_vec());
      end else n_pass++;
    end
    inc_min = 1'b0; inc_hr = 1'b0; snooze = 1'b0; stop = 1'b0; mode = 2'd0;
  endtask

  initial begin
    test_reset();
    test_tick();
    test_wrap();
    test_alarm();
    test_snooze();
    test_priority();
    test_mode_exit();
    test_reset_mid_snooze();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
